intersection_phase_scheduler: RTL

Cycle-timed phase scheduler for a two-road intersection with a pedestrian crossing and emergency-vehicle preemption. It latches requests from the North and East vehicle sensors and the pedestrian push-button, and shares the junction among them by round-robin. Each grant is sequenced through minimum green, yellow and all-red clearance intervals. It drives the active-low lamp outputs directly and exposes its state and counter for debug.

---
 rtl/intersection_phase_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: round-robin junction phase sequencer with pedestrian walk and emergency preemption
module intersection_phase_scheduler #(
  parameter int unsigned GREEN_TICKS  = 30,
  parameter int unsigned YELLOW_TICKS = 5,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned PED_TICKS    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       NorthSensor,
  input  logic       EastSensor,
  input  logic       PedButton,
  input  logic       EmergencyReq,
  input  logic       EmergencyDir,
  output logic       NorthRed,
  output logic       NorthYellow,
  output logic       NorthGreen,
  output logic       EastRed,
  output logic       EastYellow,
  output logic       EastGreen,
  output logic       Walk,
  output logic [1:0] phase,
  output logic [2:0] state,
  output logic [5:0] counter
);
  typedef enum logic [2:0] {
    S_GREEN  = 3'd0,
    S_YELLOW = 3'd1,
    S_ALLRED = 3'd2,
    S_SELECT = 3'd3,
    S_WALK   = 3'd4
  } state_t;
  localparam logic [5:0] G_LAST = 6'(GREEN_TICKS - 1);
  localparam logic [5:0] Y_LAST = 6'(YELLOW_TICKS - 1);
  localparam logic [5:0] A_LAST = 6'(ALLRED_TICKS - 1);
  localparam logic [5:0] P_LAST = 6'(PED_TICKS - 1);
  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d, rr0, rr1, pick;
  logic [5:0] counter_q, counter_d;
  logic [2:0] pend_q, pend_d, req, serve, clr;
  logic       last_veh_q, last_veh_d, other_pend, own_emerg;
  assign req        = {PedButton, EastSensor, NorthSensor};
  assign rr0        = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
  assign rr1        = (rr0 == 2'd2) ? 2'd0 : rr0 + 2'd1;
  assign pick       = pend_q[rr0] ? rr0 : pend_q[rr1] ? rr1 : pend_q[phase_q] ? phase_q : {1'b0, last_veh_q};
  assign other_pend = |(pend_q & ~(3'b001 << phase_q));
  assign own_emerg  = EmergencyReq && (EmergencyDir == phase_q[0]);
  assign serve      = (state_q == S_GREEN || state_q == S_WALK) ? (3'b001 << phase_q) : 3'b000;
  assign clr        = (state_q == S_SELECT) ? (3'b001 << phase_d) : 3'b000;
  assign pend_d     = (req & ~serve) | (pend_q & ~clr);
  // next-state, next-phase and counter sequencing
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    last_veh_d = last_veh_q;
    counter_d  = counter_q + 6'd1;
    case (state_q)
      S_GREEN: begin
        if (own_emerg) counter_d = counter_q;
        else if (EmergencyReq || (counter_q == G_LAST && other_pend)) state_d = S_YELLOW;
        else if (counter_q == G_LAST) counter_d = counter_q;
      end
      S_YELLOW: state_d = (counter_q == Y_LAST) ? S_ALLRED : S_YELLOW;
      S_ALLRED: state_d = (counter_q == A_LAST) ? S_SELECT : S_ALLRED;
      S_SELECT: begin
        phase_d    = EmergencyReq ? {1'b0, EmergencyDir} : pick;
        state_d    = (phase_d == 2'd2) ? S_WALK : S_GREEN;
        last_veh_d = (phase_d == 2'd2) ? last_veh_q : phase_d[0];
      end
      S_WALK: state_d = (EmergencyReq || counter_q == P_LAST) ? S_ALLRED : S_WALK;
      default: state_d = S_GREEN;
    endcase
    if (state_d != state_q) counter_d = 6'd0;
  end
  // state, phase, counter and pending-request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_GREEN;
      phase_q    <= 2'd0;
      counter_q  <= 6'd0;
      pend_q     <= 3'b000;
      last_veh_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      counter_q  <= counter_d;
      pend_q     <= pend_d;
      last_veh_q <= last_veh_d;
    end
  end
  // active-low lamp decode from state and phase
  always_comb begin
    NorthRed    = 1'b1;
    NorthYellow = 1'b1;
    NorthGreen  = 1'b1;
    EastRed     = 1'b1;
    EastYellow  = 1'b1;
    EastGreen   = 1'b1;
    Walk        = (state_q != S_WALK);
    if (state_q == S_GREEN) begin
      NorthGreen = phase_q[0];
      EastRed    = phase_q[0];
      EastGreen  = !phase_q[0];
      NorthRed   = !phase_q[0];
    end else if (state_q == S_YELLOW) begin
      NorthYellow = phase_q[0];
      EastRed     = phase_q[0];
      EastYellow  = !phase_q[0];
      NorthRed    = !phase_q[0];
    end else begin
      NorthRed = 1'b0;
      EastRed  = 1'b0;
    end
  end
  assign phase   = phase_q;
  assign state   = state_q;
  assign counter = counter_q;
endmodule
